// File: rtl/reset_sequencer.sv
// Staged reset release sequencer: releases NUM_STAGES reset domains in order
// once the power-on delay has elapsed and the PLL is locked.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  delayed_i,
    input  logic                  pll_locked_i,
    input  logic                  rst_req_i,
    output logic [NUM_STAGES-1:0] rst_o,
    output logic                  seq_done_o,
    output logic                  busy_o
);

    localparam int MAXD = (STAGE_DELAY > HOLD_CYCLES) ? STAGE_DELAY : HOLD_CYCLES;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int IW   = $clog2(NUM_STAGES + 1);

    localparam logic [CW-1:0] STG_LAST  = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES);

    localparam logic [1:0] S_WAIT    = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [NUM_STAGES-1:0] r_rst;
    logic                  r_done;
    logic                  r_busy;

    logic w_lock_lost;
    logic w_abort;

    // Lock loss only matters once releasing has begun; HOLD ignores lock.
    always_comb begin
        w_lock_lost = !pll_locked_i &&
                      ((r_state == S_RELEASE) || (r_state == S_DONE));
        w_abort     = (r_state != S_HOLD) && (rst_req_i || w_lock_lost);
    end

    // Sequencer FSM; all outputs come straight from these registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (w_abort) begin
            // Abort beats any same-cycle stage advance or DONE entry.
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (delayed_i && pll_locked_i) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= '0;
                        r_idx   <= IW'(1);
                        r_rst   <= r_rst << 1;
                        r_busy  <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == STG_LAST) begin
                        r_cnt <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_rst <= r_rst << 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_rst  <= '0;
                    r_done <= 1'b1;
                end
                S_HOLD: begin
                    if (rst_req_i) begin
                        r_cnt <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_rst   <= '1;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Drive outputs from registers only.
    always_comb begin
        rst_o      = r_rst;
        seq_done_o = r_done;
        busy_o     = r_busy;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the level "delay elapsed" indication from the power-on delay generator, together with PLL lock.
- Releases NUM_STAGES reset domains one at a time, with a fixed spacing between releases.
- Sits directly downstream of the delay generator inside the clock/reset generator. Its outputs drive the per-domain reset synchronizers.
- Re-asserts all resets on loss of lock or on a software reset request. After a minimum hold time it replays the release sequence.

Parameters:
- NUM_STAGES, 4, number of reset domains released in order (>=1).
- STAGE_DELAY, 16, clock cycles between consecutive stage releases, and from the last release to seq_done_o (>=1).
- HOLD_CYCLES, 8, minimum cycles all resets stay asserted after an abort (>=1).

Ports:
- clk_i  input  1  sequencer clock.
- arst_i  input  1  asynchronous reset, active-high.
- delayed_i  input  1  level from the delay generator; high = power-on delay elapsed.
- pll_locked_i  input  1  PLL lock; already synchronous to clk_i.
- rst_req_i  input  1  software reset request, sampled each cycle.
- rst_o  output  NUM_STAGES  per-domain resets, active-high; bit 0 is released first.
- seq_done_o  output  1  high when all stages are released and the final spacing has elapsed.
- busy_o  output  1  high in the HOLD and RELEASE states.

Behaviour:
- Reset is asynchronous and active-high. While arst_i is high:
  - state = WAIT_READY
  - rst_o = all ones
  - seq_done_o = 0, busy_o = 0
  - cycle counter = 0, stage index = 0
- Reset asserted mid-sequence forces these values immediately, with no clock required.
- All outputs are registered. There is no combinational path from any input to any output.
- Counter width is $clog2(max(STAGE_DELAY,HOLD_CYCLES)+1). Stage index width is $clog2(NUM_STAGES+1).
- The define "abort" is: rst_req_i high, OR pll_locked_i low while in RELEASE or DONE.
- State WAIT_READY:
  - rst_o all ones; busy_o = 0.
  - At edge E0 where delayed_i & pll_locked_i & !rst_req_i is sampled high: go to RELEASE, clear rst_o[0], counter = 0, index = 1.
  - If rst_req_i is high, go to HOLD.
- State RELEASE:
  - busy_o = 1.
  - Counter increments each cycle. When it reaches STAGE_DELAY-1, the next edge clears rst_o[index], resets the counter and increments the index.
  - rst_o[k] therefore falls at edge E0 + k*STAGE_DELAY.
  - Once the index equals NUM_STAGES, the following STAGE_DELAY-cycle count ends with: seq_done_o = 1, busy_o = 0, state DONE. seq_done_o rises at edge E0 + NUM_STAGES*STAGE_DELAY.
  - Released bits never re-assert except through abort.
- State DONE:
  - rst_o all zeros, seq_done_o = 1.
  - Stays in DONE until abort.
- Abort handling (from WAIT_READY, RELEASE or DONE):
  - At the sampling edge: rst_o = all ones, seq_done_o = 0, busy_o = 1, counter = 0, state HOLD.
  - Abort has priority over any same-cycle stage advance or DONE entry.
- State HOLD:
  - rst_o all ones.
  - Counter counts HOLD_CYCLES cycles; rst_req_i high during HOLD restarts the counter at 0. pll_locked_i is ignored in HOLD.
  - Entered at edge A with no further requests: returns to WAIT_READY at edge A+HOLD_CYCLES. busy_o falls at that edge.
  - The earliest new E0 is A+HOLD_CYCLES+1.
- Edge cases:
  - delayed_i falling after E0 is ignored; it is only sampled in WAIT_READY.
  - STAGE_DELAY=1 releases stages on consecutive edges.
  - NUM_STAGES=1 releases the single stage at E0 and raises seq_done_o STAGE_DELAY edges later.
- Invariant: rst_o is always thermometer-shaped, i.e. zeros in low bits and ones in high bits.

Test Plan:
All scenarios use NUM_STAGES=4, STAGE_DELAY=3, HOLD_CYCLES=5.
- Power-up: arst_i high for 3 cycles, then low; pll_locked_i=1; delayed_i rises at cycle 10 (sampled at E0) → rst_o steps 4'b1110, 4'b1100, 4'b1000, 4'b0000 at E0, E0+3, E0+6, E0+9; seq_done_o rises at E0+12; busy_o high from E0 to E0+12.
- Lock gating: delayed_i=1 while pll_locked_i=0 for 20 cycles → rst_o stays 4'b1111 and busy_o stays 0. The release sequence starts at the first edge where lock is sampled high.
- Lock loss mid-sequence: pll_locked_i dropped for 1 cycle, sampled at E0+4 (rst_o=4'b1100) → rst_o=4'b1111 and seq_done_o=0 at that edge; WAIT_READY at +5; a new E0 at +6 replays the full sequence.
- Software request during DONE plus request during HOLD: rst_req_i pulse at edge A, second pulse at A+2 → all resets asserted at A; HOLD exits at A+2+5 = A+7; re-release starts at A+8.
- Async reset mid-RELEASE: arst_i asserted between clock edges → rst_o=4'b1111, seq_done_o=0, busy_o=0 immediately, with no clock edge needed. After deassertion the sequence restarts from WAIT_READY.
- Simultaneous abort and advance: rst_req_i sampled high on the edge where rst_o[2] would clear → rst_o=4'b1111 (abort wins), state HOLD. The thermometer invariant holds on every cycle of the whole test.
